// File: rtl/mem_pkg.sv
// mem_pkg: access-mode enum and byte-lane helpers shared by the data memory and the core's MEM stage.
package mem_pkg;
  typedef enum logic [2:0] {NONE, BYTE, HALFWORD, WORD, WORDLEFT, WORDRIGHT} rw_mode_e;
  typedef enum logic {CLEAR, IDLE} ctrl_state_e;
  function automatic logic [3:0] lane_mask(input logic [2:0] m, input logic [1:0] o);
    return m == BYTE ? 4'b0001 << o : m == HALFWORD ? 4'b0011 << o : m == WORD ? 4'hF :
           m == WORDLEFT ? 4'hF >> ~o : m == WORDRIGHT ? 4'hF << o : 4'h0;
  endfunction
  // swl moves the high register bytes down to the low lanes; everything else shifts up by the offset
  function automatic logic [31:0] store_shift(input logic [2:0] m, input logic [1:0] o, input logic [31:0] d);
    return m == WORDLEFT ? d >> {~o, 3'b000} : d << {o, 3'b000};
  endfunction
  function automatic logic [31:0] load_merge(input logic [2:0] m, input logic [1:0] o, input logic u,
                                             input logic [31:0] w, input logic [31:0] rt);
    logic [31:0] s;
    s = w >> {o, 3'b000};
    return m == BYTE ? {{24{s[7] & ~u}}, s[7:0]} :
           m == HALFWORD ? {{16{s[15] & ~u}}, s[15:0]} :
           m == WORDLEFT ? (w << {~o, 3'b000}) | (rt & ~(32'hFFFFFFFF << {~o, 3'b000})) :
           m == WORDRIGHT ? s | (rt & ~(32'hFFFFFFFF >> {o, 3'b000})) : w;
  endfunction
endpackage

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: load/store request-response bus plus instruction-fetch port.
interface data_memory_ctrl_if;
  logic req_valid, req_ready, req_write, req_unsigned, resp_valid, resp_fault, busy;
  logic [2:0] req_mode;
  logic [31:0] req_address, req_data, resp_data, pc_address, pc_data;
  modport master(output req_valid, req_write, req_mode, req_unsigned, req_address, req_data, pc_address,
                 input req_ready, resp_valid, resp_data, resp_fault, pc_data, busy);
  modport slave(input req_valid, req_write, req_mode, req_unsigned, req_address, req_data, pc_address,
                output req_ready, resp_valid, resp_data, resp_fault, pc_data, busy);
endinterface

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: word RAM with one byte-enabled write port and two registered read-before-write read ports.
module byte_lane_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [31:0]   rd0,
  output logic [31:0]   rd1
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk) begin
    rd0 <= mem[ra0];
    rd1 <= mem[ra1];
    for (int i = 0; i < 4; i++) if (we && be[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable data/fetch memory with lwl/lwr/swl/swr merging, fault checks and zero-fill.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic clk,
  input logic rst,
  data_memory_ctrl_if.slave bus
);
  localparam int WA = ADDR_WIDTH - 2;
  ctrl_state_e state_q, state_d;
  logic [WA-1:0] cnt_q, cnt_d, wa;
  logic rv_q, rv_d, rw_q, rw_d, rf_q, rf_d, ru_q, ru_d, pc_ok_q, pc_ok_d;
  logic [2:0] rm_q, rm_d;
  logic [1:0] ro_q, ro_d;
  logic [31:0] rt_q, rt_d, wd, rd0, rd1;
  logic accept, fault, we;
  logic [3:0] be;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rw_q    <= 1'b0;
      rf_q    <= 1'b0;
      ru_q    <= 1'b0;
      rm_q    <= 3'd0;
      ro_q    <= 2'd0;
      rt_q    <= 32'h0;
      pc_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rw_q    <= rw_d;
      rf_q    <= rf_d;
      ru_q    <= ru_d;
      rm_q    <= rm_d;
      ro_q    <= ro_d;
      rt_q    <= rt_d;
      pc_ok_q <= pc_ok_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = IDLE;
    end
  end
  always_comb begin
    accept = bus.req_valid && state_q == IDLE;
    fault  = (bus.req_address >> ADDR_WIDTH) != 32'h0 || bus.req_mode == NONE || bus.req_mode > WORDRIGHT ||
             (bus.req_mode == HALFWORD && bus.req_address[0]) ||
             (bus.req_mode == WORD && bus.req_address[1:0] != 2'd0);
    we      = state_q == CLEAR || (accept && bus.req_write && !fault);
    be      = state_q == CLEAR ? 4'hF : lane_mask(bus.req_mode, bus.req_address[1:0]);
    wa      = state_q == CLEAR ? cnt_q : bus.req_address[ADDR_WIDTH-1:2];
    wd      = state_q == CLEAR ? 32'h0 : store_shift(bus.req_mode, bus.req_address[1:0], bus.req_data);
    rv_d    = accept;
    rw_d    = bus.req_write;
    rf_d    = fault;
    ru_d    = bus.req_unsigned;
    rm_d    = bus.req_mode;
    ro_d    = bus.req_address[1:0];
    rt_d    = bus.req_data;
    pc_ok_d = state_q == IDLE && (bus.pc_address >> ADDR_WIDTH) == 32'h0;
  end
  // the RAM read is registered, so merging happens on the captured request fields
  assign bus.req_ready  = state_q == IDLE;
  assign bus.busy       = state_q == CLEAR;
  assign bus.resp_valid = rv_q;
  assign bus.resp_fault = rv_q && rf_q;
  assign bus.resp_data  = (rv_q && !rw_q && !rf_q) ? load_merge(rm_q, ro_q, ru_q, rd0, rt_q) : 32'h0;
  assign bus.pc_data    = pc_ok_q ? rd1 : 32'h0;
  byte_lane_ram #(.AW(WA)) u_ram (
    .clk(clk),
    .we(we),
    .be(be),
    .wa(wa),
    .wd(wd),
    .ra0(bus.req_address[ADDR_WIDTH-1:2]),
    .ra1(bus.pc_address[ADDR_WIDTH-1:2]),
    .rd0(rd0),
    .rd1(rd1)
  );
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed stimulus with a response scoreboard for data_memory_ctrl (ADDR_WIDTH=6).
module tb_data_memory_ctrl;
  import mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];
  logic [32:0] e;
  data_memory_ctrl_if bus();
  data_memory_ctrl #(.ADDR_WIDTH(6), .CLEAR_ON_RESET(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got fault=%b data=%h expected no response", bus.resp_fault, bus.resp_data);
      end else begin
        e = exp_q.pop_front();
        chk("resp", {bus.resp_fault, bus.resp_data}, e);
      end
    end
  end
  task automatic issue(input logic w, input logic [2:0] m, input logic u, input logic [31:0] a,
                       input logic [31:0] d, input logic f, input logic [31:0] x);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_mode = m;
    bus.req_unsigned = u;
    bus.req_address = a;
    bus.req_data = d;
    exp_q.push_back({f, x});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_fill();
    int n = 0;
    while (bus.busy && n < 100) begin
      chk("ready_in_fill", {32'h0, bus.req_ready}, 33'h0);
      chk("pc_in_fill", {1'b0, bus.pc_data}, 33'h0);
      @(posedge clk); #1;
      n++;
    end
    chk("fill_cycles", 33'(n), 33'd16);
    chk("ready_after_fill", {32'h0, bus.req_ready}, 33'h1);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_mode = 3'd0;
    bus.req_unsigned = 1'b0;
    bus.req_address = 32'h0;
    bus.req_data = 32'h0;
    bus.pc_address = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {32'h0, bus.busy}, 33'h1);
    chk("rst_ready", {32'h0, bus.req_ready}, 33'h0);
    chk("rst_resp_valid", {32'h0, bus.resp_valid}, 33'h0);
    chk("rst_resp", {bus.resp_fault, bus.resp_data}, 33'h0);
    chk("rst_pc_data", {1'b0, bus.pc_data}, 33'h0);
    rst = 1'b1;
    wait_fill();
    for (int i = 0; i < 64; i += 4) issue(0, WORD, 0, 32'(i), 32'h0, 0, 32'h0);
    issue(1, WORD, 0, 32'h10, 32'hA1B2C3D4, 0, 32'h0);
    issue(0, BYTE, 0, 32'h11, 32'h0, 0, 32'hFFFFFFC3);
    issue(0, BYTE, 1, 32'h11, 32'h0, 0, 32'h000000C3);
    issue(0, HALFWORD, 0, 32'h12, 32'h0, 0, 32'hFFFFA1B2);
    issue(0, HALFWORD, 1, 32'h10, 32'h0, 0, 32'h0000C3D4);
    issue(0, BYTE, 0, 32'h13, 32'h0, 0, 32'hFFFFFFA1);
    issue(1, WORD, 0, 32'h20, 32'h44332211, 0, 32'h0);
    issue(0, WORDLEFT, 0, 32'h21, 32'hAABBCCDD, 0, 32'h2211CCDD);
    issue(0, WORDRIGHT, 0, 32'h21, 32'hAABBCCDD, 0, 32'hAA443322);
    issue(0, WORDLEFT, 0, 32'h23, 32'hAABBCCDD, 0, 32'h44332211);
    issue(0, WORDRIGHT, 0, 32'h20, 32'hAABBCCDD, 0, 32'h44332211);
    issue(0, WORDLEFT, 0, 32'h20, 32'hAABBCCDD, 0, 32'h11BBCCDD);
    issue(1, WORD, 0, 32'h20, 32'h0, 0, 32'h0);
    issue(1, WORDLEFT, 0, 32'h22, 32'h11223344, 0, 32'h0);
    issue(0, WORD, 0, 32'h20, 32'h0, 0, 32'h00112233);
    issue(1, WORD, 0, 32'h20, 32'h0, 0, 32'h0);
    issue(1, WORDRIGHT, 0, 32'h21, 32'h11223344, 0, 32'h0);
    issue(0, WORD, 0, 32'h20, 32'h0, 0, 32'h22334400);
    issue(1, BYTE, 0, 32'h1A, 32'h000000EE, 0, 32'h0);
    issue(1, HALFWORD, 0, 32'h1E, 32'h00007788, 0, 32'h0);
    issue(0, WORD, 0, 32'h18, 32'h0, 0, 32'h00EE0000);
    issue(0, WORD, 0, 32'h1C, 32'h0, 0, 32'h77880000);
    issue(0, WORD, 0, 32'h02, 32'h0, 1, 32'h0);
    issue(1, HALFWORD, 0, 32'h03, 32'hFFFFFFFF, 1, 32'h0);
    issue(0, WORD, 0, 32'h00010000, 32'h0, 1, 32'h0);
    issue(1, WORD, 0, 32'h00010000, 32'hDEADBEEF, 1, 32'h0);
    issue(1, BYTE, 0, 32'h40, 32'h000000FF, 1, 32'h0);
    issue(0, NONE, 0, 32'h10, 32'h0, 1, 32'h0);
    issue(1, 3'd7, 0, 32'h0, 32'hFFFFFFFF, 1, 32'h0);
    issue(0, WORD, 0, 32'h00, 32'h0, 0, 32'h0);
    bus.pc_address = 32'h8;
    issue(1, WORD, 0, 32'h8, 32'h12345678, 0, 32'h0);
    issue(1, WORD, 0, 32'h8, 32'hCAFEF00D, 0, 32'h0);
    chk("pc_old_word", {1'b0, bus.pc_data}, {1'b0, 32'h12345678});
    issue(0, WORD, 0, 32'h8, 32'h0, 0, 32'hCAFEF00D);
    chk("pc_new_word", {1'b0, bus.pc_data}, {1'b0, 32'hCAFEF00D});
    bus.pc_address = 32'h43;
    @(posedge clk); #1;
    chk("pc_out_of_range", {1'b0, bus.pc_data}, 33'h0);
    bus.pc_address = 32'h13;
    @(posedge clk); #1;
    chk("pc_ignores_low_bits", {1'b0, bus.pc_data}, {1'b0, 32'hA1B2C3D4});
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_mode = WORD;
    bus.req_address = 32'h8;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("drop_resp_valid", {32'h0, bus.resp_valid}, 33'h0);
    chk("busy_reasserted", {32'h0, bus.busy}, 33'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_fill();
    issue(0, WORD, 0, 32'h8, 32'h0, 0, 32'h0);
    issue(0, WORD, 0, 32'h10, 32'h0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 33'(exp_q.size()), 33'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
